// File: rtl/accu_pkg.sv
// Shared opcode encoding and sizing helper for the accumulator datapath.
package accu_pkg;
  typedef logic [2:0] op_t;

  localparam op_t OP_PASS_A = 3'b000;
  localparam op_t OP_SUB    = 3'b001;
  localparam op_t OP_PASS_B = 3'b010;
  localparam op_t OP_ADD    = 3'b011;
  localparam op_t OP_NAND   = 3'b100;
  localparam op_t OP_AND    = 3'b101;
  localparam op_t OP_XOR    = 3'b110;
  localparam op_t OP_ADC    = 3'b111;

  // Index width; a single accumulator still gets a 1-bit select.
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/accu_alu.sv
// Combinational ALU: one opcode over A/B (+carry in) producing result, C and Z.
module accu_alu
  import accu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             z
);
  // One extra bit captures carry out for adds and borrow for subtract.
  logic [WIDTH:0] ext;

  always_comb begin
    ext    = '0;
    result = '0;
    c      = 1'b0;
    case (op_t'(op))
      OP_PASS_A: result = a;
      OP_SUB: begin
        ext    = {1'b0, a} - {1'b0, b};
        result = ext[WIDTH-1:0];
        c      = ext[WIDTH];
      end
      OP_PASS_B: result = b;
      OP_ADD: begin
        ext    = {1'b0, a} + {1'b0, b};
        result = ext[WIDTH-1:0];
        c      = ext[WIDTH];
      end
      OP_NAND: result = ~(a & b);
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      default: begin
        ext    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        result = ext[WIDTH-1:0];
        c      = ext[WIDTH];
      end
    endcase
  end

  assign z = (result == '0);
endmodule

// File: rtl/accu_datapath.sv
// Multi-accumulator ALU datapath with a one-entry registered result over valid/ready.
module accu_datapath
  import accu_pkg::*;
#(
  parameter int  WIDTH   = 4,
  parameter int  NUM_ACC = 2,
  localparam int SEL_W   = sel_w(NUM_ACC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_store,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_c,
  output logic             out_z,
  output logic [WIDTH-1:0] acc_mon
);
  logic [WIDTH-1:0]   acc [NUM_ACC];
  logic [NUM_ACC-1:0] cf;

  logic             sel_ok, accept, cin;
  logic [WIDTH-1:0] a, res;
  logic             res_c, res_z;

  // Out-of-range selects read as zero and never write back.
  assign sel_ok   = int'(in_sel) < NUM_ACC;
  assign a        = sel_ok ? acc[in_sel] : '0;
  assign cin      = sel_ok ? cf[in_sel] : 1'b0;
  assign acc_mon  = a;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  accu_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (in_op),
    .a      (a),
    .b      (in_data),
    .cin    (cin),
    .result (res),
    .c      (res_c),
    .z      (res_z)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
      cf        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_c     <= 1'b0;
      out_z     <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= res;
      out_c     <= res_c;
      out_z     <= res_z;
      if (in_store && sel_ok) begin
        acc[in_sel] <= res;
        cf[in_sel]  <= res_c;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_accu_datapath.sv
// Scoreboard bench: directed scenarios plus random traffic against an arithmetic reference model.
module tb_accu_datapath;
  localparam int W = 4, N = 3, SW = 2;
  localparam int M = (1 << W) - 1;

  logic          clk = 1'b0, reset = 1'b1;
  logic          in_valid = 1'b0, in_store = 1'b0, out_ready = 1'b1;
  logic [W-1:0]  in_data = '0;
  logic [2:0]    in_op = '0;
  logic [SW-1:0] in_sel = '0;
  logic          in_ready, out_valid, out_c, out_z;
  logic [W-1:0]  out_data, acc_mon;

  accu_datapath #(.WIDTH(W), .NUM_ACC(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_op(in_op), .in_sel(in_sel), .in_store(in_store),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_c(out_c), .out_z(out_z), .acc_mon(acc_mon)
  );

  always #5 clk = ~clk;

  int cnt = 0, bad = 0;
  typedef struct { int d; int c; int z; } exp_t;
  exp_t sbq[$];
  int acc_m[N];
  int cf_m[N];
  bit mv = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    cnt++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_op(input int op, input int a, input int b, input int cin);
    exp_t e;
    int s;
    e.c = 0;
    case (op)
      0: e.d = a;
      1: begin e.d = (a - b) & M; e.c = (a < b) ? 1 : 0; end
      2: e.d = b;
      3: begin s = a + b; e.d = s & M; e.c = s >> W; end
      4: e.d = ~(a & b) & M;
      5: e.d = a & b;
      6: e.d = a ^ b;
      default: begin s = a + b + cin; e.d = s & M; e.c = s >> W; end
    endcase
    e.z = (e.d == 0) ? 1 : 0;
    return e;
  endfunction

  // Reference model: evaluates the beat that the coming rising edge will see.
  always @(negedge clk) begin
    int s;
    exp_t e;
    s = int'(in_sel);
    chk("out_valid", int'(out_valid), int'(mv));
    chk("in_ready", int'(in_ready), int'(!mv || out_ready));
    chk("acc_mon", int'(acc_mon), (s < N) ? acc_m[s] : 0);
    if (reset) begin
      for (int i = 0; i < N; i++) begin acc_m[i] = 0; cf_m[i] = 0; end
      sbq.delete();
      mv = 1'b0;
    end else if (in_valid && (!mv || out_ready)) begin
      e = ref_op(int'(in_op), (s < N) ? acc_m[s] : 0, int'(in_data), (s < N) ? cf_m[s] : 0);
      sbq.push_back(e);
      if (in_store && s < N) begin acc_m[s] = e.d; cf_m[s] = e.c; end
      mv = 1'b1;
    end else if (out_ready) begin
      mv = 1'b0;
    end
  end

  // Monitor: each result handed over at the next edge is checked against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sbq.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("sb_data", int'(out_data), e.d);
        chk("sb_c", int'(out_c), e.c);
        chk("sb_z", int'(out_z), e.z);
      end
    end
  end

  task automatic beat(input logic [2:0] op, input logic [W-1:0] d, input logic [SW-1:0] sel,
                      input logic st);
    bit took = 1'b0;
    @(posedge clk); #2;
    in_valid = 1'b1; in_op = op; in_data = d; in_sel = sel; in_store = st;
    for (int i = 0; i < 20 && !took; i++) begin
      @(negedge clk);
      took = in_ready;
    end
    if (!took) chk("beat_timeout", 0, 1);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string n, input int d, input int c, input int z);
    chk({n, "_d"}, int'(out_data), d);
    chk({n, "_c"}, int'(out_c), c);
    chk({n, "_z"}, int'(out_z), z);
  endtask

  task automatic expect_acc(input string n, input logic [SW-1:0] sel, input int v);
    in_sel = sel; #1;
    chk(n, int'(acc_mon), v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk); #2;
    reset = 1'b0;
    chk("rst_valid", int'(out_valid), 0);
    expect_out("rst", 0, 0, 0);

    beat(3'b011, 4'd9, 2'd0, 1'b1); expect_out("add9", 9, 0, 0);
    beat(3'b011, 4'd9, 2'd0, 1'b1); expect_out("add9b", 2, 1, 0);
    expect_acc("acc0_2", 2'd0, 2);
    beat(3'b010, 4'd3, 2'd0, 1'b1);
    beat(3'b001, 4'd5, 2'd0, 1'b0); expect_out("sub5", 14, 1, 0);
    expect_acc("acc0_3", 2'd0, 3);
    beat(3'b001, 4'd3, 2'd0, 1'b1); expect_out("sub3", 0, 0, 1);

    beat(3'b010, 4'hF, 2'd1, 1'b1);
    beat(3'b011, 4'd1, 2'd1, 1'b1); expect_out("mw_add", 0, 1, 1);
    beat(3'b111, 4'd0, 2'd1, 1'b1); expect_out("mw_adc", 1, 0, 0);
    expect_acc("acc0_kept", 2'd0, 0);

    beat(3'b010, 4'hC, 2'd0, 1'b1);
    beat(3'b100, 4'hA, 2'd0, 1'b0); expect_out("nand", 7, 0, 0);
    expect_acc("acc0_c", 2'd0, 12);
    beat(3'b010, 4'hF, 2'd0, 1'b1);
    beat(3'b110, 4'hF, 2'd0, 1'b0); expect_out("xor", 0, 0, 1);

    beat(3'b011, 4'd5, 2'd3, 1'b1); expect_out("oor_add", 5, 0, 0);
    expect_acc("oor_mon", 2'd3, 0);

    // Backpressure: second beat must wait behind the held result.
    @(posedge clk); #2;
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'b011; in_data = 4'd1; in_sel = 2'd0; in_store = 1'b1;
    @(posedge clk); #2;
    in_data = 4'd2;
    repeat (3) @(posedge clk); #2;
    chk("bp_ready", int'(in_ready), 0);
    chk("bp_valid", int'(out_valid), 1);
    expect_out("bp_hold", 0, 1, 1);
    chk("bp_acc", int'(acc_mon), 0);
    out_ready = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    expect_out("bp_second", 2, 0, 0);

    // Reset while stalled with a beat on the input.
    beat(3'b010, 4'hF, 2'd1, 1'b1);
    beat(3'b011, 4'd1, 2'd1, 1'b1);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'b011; in_data = 4'd3; in_sel = 2'd0; in_store = 1'b1;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("rst2_valid", int'(out_valid), 0);
    expect_out("rst2", 0, 0, 0);
    for (int i = 0; i < N; i++) expect_acc("rst2_acc", SW'(i), 0);
    beat(3'b111, 4'd0, 2'd1, 1'b0); expect_out("rst2_cf", 0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      reset     = ($urandom_range(0, 59) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 3'($urandom_range(0, 7));
      in_data   = W'($urandom_range(0, M));
      in_sel    = SW'($urandom_range(0, 3));
      in_store  = $urandom_range(0, 1) != 0;
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #2;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk); #2;
    chk("drain", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", cnt, bad);
    $finish;
  end
endmodule
